// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller: ALUop bit indices,
// MIPS opcode/funct codes, FSM state encoding and the decoder output bundle.
package alu_issue_pkg;

    localparam int NUM_OPS = 12;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_AND  = 2;
    localparam int OP_OR   = 3;
    localparam int OP_NOR  = 4;
    localparam int OP_XOR  = 5;
    localparam int OP_SLT  = 6;
    localparam int OP_SLTU = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_LUI  = 11;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        B_RT   = 2'd0,
        B_SEXT = 2'd1,
        B_ZEXT = 2'd2
    } b_sel_t;

    typedef struct packed {
        logic [NUM_OPS-1:0] op;
        logic               a_shamt;
        b_sel_t             b_sel;
        logic [4:0]         dest;
        logic               writes;
        logic               beq;
        logic               bne;
        logic               trap;
        logic               illegal;
    } dec_t;

    function automatic logic [NUM_OPS-1:0] onehot(input int idx);
        return {{(NUM_OPS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction decoder: one-hot ALU operation, operand selects,
// destination register and writeback/branch/trap/illegal classification.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = inst[31:26];
    assign funct  = inst[5:0];

    // Classify the instruction; unknown encodings leave op at zero and flag illegal.
    always_comb begin
        dec       = '0;
        dec.b_sel = B_RT;
        case (opcode)
            OPC_RTYPE: begin
                dec.writes = 1'b1;
                dec.dest   = inst[15:11];
                case (funct)
                    FN_SLL:  begin dec.op = onehot(OP_SLL); dec.a_shamt = 1'b1; end
                    FN_SRL:  begin dec.op = onehot(OP_SRL); dec.a_shamt = 1'b1; end
                    FN_SRA:  begin dec.op = onehot(OP_SRA); dec.a_shamt = 1'b1; end
                    FN_SLLV: dec.op = onehot(OP_SLL);
                    FN_SRLV: dec.op = onehot(OP_SRL);
                    FN_SRAV: dec.op = onehot(OP_SRA);
                    FN_ADD:  begin dec.op = onehot(OP_ADD); dec.trap = 1'b1; end
                    FN_ADDU: dec.op = onehot(OP_ADD);
                    FN_SUB:  begin dec.op = onehot(OP_SUB); dec.trap = 1'b1; end
                    FN_SUBU: dec.op = onehot(OP_SUB);
                    FN_AND:  dec.op = onehot(OP_AND);
                    FN_OR:   dec.op = onehot(OP_OR);
                    FN_XOR:  dec.op = onehot(OP_XOR);
                    FN_NOR:  dec.op = onehot(OP_NOR);
                    FN_SLT:  dec.op = onehot(OP_SLT);
                    FN_SLTU: dec.op = onehot(OP_SLTU);
                    default: begin
                        dec.writes  = 1'b0;
                        dec.dest    = 5'd0;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            OPC_ADDI:  begin dec.op = onehot(OP_ADD);  dec.b_sel = B_SEXT; dec.trap = 1'b1; end
            OPC_ADDIU: begin dec.op = onehot(OP_ADD);  dec.b_sel = B_SEXT; end
            OPC_SLTI:  begin dec.op = onehot(OP_SLT);  dec.b_sel = B_SEXT; end
            OPC_SLTIU: begin dec.op = onehot(OP_SLTU); dec.b_sel = B_SEXT; end
            OPC_ANDI:  begin dec.op = onehot(OP_AND);  dec.b_sel = B_ZEXT; end
            OPC_ORI:   begin dec.op = onehot(OP_OR);   dec.b_sel = B_ZEXT; end
            OPC_XORI:  begin dec.op = onehot(OP_XOR);  dec.b_sel = B_ZEXT; end
            OPC_LUI:   begin dec.op = onehot(OP_LUI);  dec.b_sel = B_ZEXT; end
            OPC_BEQ:   begin dec.op = onehot(OP_SUB);  dec.beq = 1'b1; end
            OPC_BNE:   begin dec.op = onehot(OP_SUB);  dec.bne = 1'b1; end
            default:   dec.illegal = 1'b1;
        endcase

        if (!dec.illegal && opcode != OPC_RTYPE && !dec.beq && !dec.bne) begin
            dec.writes = 1'b1;
            dec.dest   = inst[20:16];
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle ALU issue controller: WAIT -> DECODE -> EXEC -> WB per instruction.
// Optional feature macro ALU_ISSUE_TRAP_EN: signed-overflow trap for add/sub/addi.
//
// state  | meaning
// RST    | held in reset; all outputs low
// WAIT   | Inst_Ready high, waiting for an instruction
// DECODE | register file read, ALU operands registered
// EXEC   | ALUop valid for this cycle only; ALU result captured
// WB     | writeback / branch / illegal / trap strobes
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  Inst_Valid,
    output logic                  Inst_Ready,
    input  logic [31:0]           Instruction,
    output logic [4:0]            Rs_Addr,
    output logic [4:0]            Rt_Addr,
    input  logic [DATA_WIDTH-1:0] Rs_Data,
    input  logic [DATA_WIDTH-1:0] Rt_Data,
    output logic [OP_WIDTH-1:0]   ALUop,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    input  logic [DATA_WIDTH-1:0] Result,
    input  logic                  Zero,
    input  logic                  Overflow,
    output logic                  Wb_Wen,
    output logic [4:0]            Wb_Addr,
    output logic [DATA_WIDTH-1:0] Wb_Data,
    output logic                  Branch_Taken,
    output logic [31:0]           Branch_Offset,
    output logic                  Illegal,
    output logic                  Exc_Ov
);

    state_t      state;
    logic [31:0] inst_q;
    dec_t        dec;
    logic        trapped;

    alu_issue_decode u_decode (
        .inst (inst_q),
        .dec  (dec)
    );

    // inst_q is stable from DECODE through WB, so the decode is reused in EXEC.
    assign Rs_Addr = (state == ST_DECODE) ? inst_q[25:21] : 5'd0;
    assign Rt_Addr = (state == ST_DECODE) ? inst_q[20:16] : 5'd0;

`ifdef ALU_ISSUE_TRAP_EN
    assign trapped = dec.trap & Overflow;
`else
    logic [1:0] unused_trap;
    assign unused_trap = {dec.trap, Overflow};
    assign trapped     = 1'b0;
`endif

    // Sequencer FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_RST;
            inst_q        <= '0;
            Inst_Ready    <= 1'b0;
            ALUop         <= '0;
            ALU_A         <= '0;
            ALU_B         <= '0;
            Wb_Wen        <= 1'b0;
            Wb_Addr       <= '0;
            Wb_Data       <= '0;
            Branch_Taken  <= 1'b0;
            Branch_Offset <= '0;
            Illegal       <= 1'b0;
            Exc_Ov        <= 1'b0;
        end else begin
            ALUop        <= '0;
            Wb_Wen       <= 1'b0;
            Branch_Taken <= 1'b0;
            Illegal      <= 1'b0;
            Exc_Ov       <= 1'b0;
            case (state)
                ST_RST: begin
                    Inst_Ready <= 1'b1;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (Inst_Valid && Inst_Ready) begin
                        inst_q     <= Instruction;
                        Inst_Ready <= 1'b0;
                        state      <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    ALUop <= dec.op;
                    ALU_A <= dec.a_shamt ? DATA_WIDTH'(inst_q[10:6]) : Rs_Data;
                    case (dec.b_sel)
                        B_SEXT:  ALU_B <= {{(DATA_WIDTH-16){inst_q[15]}}, inst_q[15:0]};
                        B_ZEXT:  ALU_B <= {{(DATA_WIDTH-16){1'b0}}, inst_q[15:0]};
                        default: ALU_B <= Rt_Data;
                    endcase
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    Wb_Wen        <= dec.writes && (dec.dest != 5'd0) && !dec.illegal && !trapped;
                    Wb_Addr       <= dec.dest;
                    Wb_Data       <= Result;
                    Branch_Taken  <= (dec.beq & Zero) | (dec.bne & ~Zero);
                    Branch_Offset <= {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
                    Illegal       <= dec.illegal;
                    Exc_Ov        <= trapped;
                    state         <= ST_WB;
                end
                ST_WB: begin
                    Inst_Ready <= 1'b1;
                    state      <= ST_WAIT;
                end
                default: begin
                    Inst_Ready <= 1'b0;
                    state      <= ST_RST;
                end
            endcase
        end
    end

endmodule
